// File: rtl/humidity_responder_if.sv
// humidity_responder_if: payload and status bundle of the humidity responder.
//   hum_in      [15:0] humidity payload (high byte, low byte), host -> responder
//   temp_in     [15:0] temperature payload (high byte, low byte), host -> responder
//   busy               high from a valid start until the frame ends
//   frame_done         one-cycle pulse when the line is released after the end slot
//   short_start        one-cycle pulse when a host low pulse was too short
//   mstate      [2:0]  current FSM state code
// The open-drain Data_H pin stays a plain inout port on the responder so that the
// pull-up and the tristate resolution live on a real net.
interface humidity_responder_if;
  logic [15:0] hum_in;
  logic [15:0] temp_in;
  logic        busy;
  logic        frame_done;
  logic        short_start;
  logic [2:0]  mstate;

  // Payload source / status observer side.
  modport master (
    output hum_in,
    output temp_in,
    input  busy,
    input  frame_done,
    input  short_start,
    input  mstate
  );

  // Responder side.
  modport slave (
    input  hum_in,
    input  temp_in,
    output busy,
    output frame_done,
    output short_start,
    output mstate
  );
endinterface

// File: rtl/humidity_responder.sv
// humidity_responder: emulates a single-wire humidity/temperature sensor.
// A host pulls Data_H low for at least T_START_MIN cycles and releases it; the
// responder then answers with a response preamble followed by a 40-bit frame
// {hum, temp, checksum}, MSB first, each bit a low slot plus a released-high slot
// whose length encodes the bit value.
// Ports:
//   clk1M   1 MHz clock, all logic on its rising edge
//   rst_n   asynchronous active-low reset
//   Data_H  open-drain data line; driven only to 0 or z, pull-up is external
//   bus     humidity_responder_if.slave: hum_in, temp_in in; busy, frame_done,
//           short_start, mstate out
module humidity_responder #(
  parameter int unsigned T_START_MIN = 1000,
  parameter int unsigned T_WAIT      = 30,
  parameter int unsigned T_RESP      = 80,
  parameter int unsigned T_BIT_LOW   = 50,
  parameter int unsigned T_ZERO      = 26,
  parameter int unsigned T_ONE       = 70
) (
  input  logic                       clk1M,
  input  logic                       rst_n,
  inout  wire                        Data_H,
  humidity_responder_if.slave        bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HOST_LOW  = 3'd1;
  localparam logic [2:0] WAIT      = 3'd2;
  localparam logic [2:0] RESP_LOW  = 3'd3;
  localparam logic [2:0] RESP_HIGH = 3'd4;
  localparam logic [2:0] BIT_LOW   = 3'd5;
  localparam logic [2:0] BIT_HIGH  = 3'd6;
  localparam logic [2:0] END_LOW   = 3'd7;

  // Terminal counts: a state lasting N cycles leaves when cnt reaches N-1.
  localparam logic [15:0] START_MIN_M1 = 16'(T_START_MIN - 1);
  localparam logic [15:0] WAIT_M1      = 16'(T_WAIT - 1);
  localparam logic [15:0] RESP_M1      = 16'(T_RESP - 1);
  localparam logic [15:0] BIT_LOW_M1   = 16'(T_BIT_LOW - 1);
  localparam logic [15:0] ZERO_M1      = 16'(T_ZERO - 1);
  localparam logic [15:0] ONE_M1       = 16'(T_ONE - 1);

  logic        sync1_q, sync2_q, prev_q;
  logic        fall, rise;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [39:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        short_start_q, short_start_d;
  logic        drive_low;
  logic [7:0]  chk;
  logic [15:0] high_end;

  // Synchronizer and edge history idle at 1 so that reset never looks like an edge.
  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= Data_H;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;
  assign rise = ~prev_q & sync2_q;

  // 8-bit result width makes the sum wrap mod 256.
  assign chk = bus.hum_in[15:8] + bus.hum_in[7:0] + bus.temp_in[15:8] + bus.temp_in[7:0];

  assign high_end = shift_q[39] ? ONE_M1 : ZERO_M1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    short_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = HOST_LOW;
          cnt_d   = '0;
        end
      end

      HOST_LOW: begin
        if (rise) begin
          if (cnt_q >= START_MIN_M1) begin
            state_d = WAIT;
            cnt_d   = '0;
            busy_d  = 1'b1;
            // Payload is frozen here; later input changes only reach the next frame.
            shift_d = {bus.hum_in, bus.temp_in, chk};
          end else begin
            state_d       = IDLE;
            short_start_d = 1'b1;
          end
        end else if (!sync2_q && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      WAIT: begin
        if (cnt_q == WAIT_M1) begin
          state_d = RESP_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESP_LOW: begin
        if (cnt_q == RESP_M1) begin
          state_d = RESP_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESP_HIGH: begin
        if (cnt_q == RESP_M1) begin
          state_d   = BIT_LOW;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      BIT_LOW: begin
        if (cnt_q == BIT_LOW_M1) begin
          state_d = BIT_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      BIT_HIGH: begin
        if (cnt_q == high_end) begin
          cnt_d     = '0;
          shift_d   = {shift_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? END_LOW : BIT_LOW;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      END_LOW: begin
        if (cnt_q == BIT_LOW_M1) begin
          state_d      = IDLE;
          cnt_d        = '0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      short_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      short_start_q <= short_start_d;
    end
  end

  // Decoded straight from the state register: the line can only be pulled low in
  // the three low states, and an asynchronous reset releases it at once.
  assign drive_low = (state_q == RESP_LOW) || (state_q == BIT_LOW) || (state_q == END_LOW);
  assign Data_H    = drive_low ? 1'b0 : 1'bz;

  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.short_start = short_start_q;
  assign bus.mstate      = state_q;

endmodule

// File: tb/tb_humidity_responder.sv
// Self-checking bench for humidity_responder: plays the host on the open-drain
// line, decodes every responder frame from slot lengths and compares it with a
// frame built from the payload by plain arithmetic.
module tb_humidity_responder;

  localparam int T_START_MIN = 1000;
  localparam int T_WAIT      = 30;
  localparam int T_RESP      = 80;
  localparam int T_BIT_LOW   = 50;
  localparam int T_ZERO      = 26;
  localparam int T_ONE       = 70;
  localparam int RUN_MAX     = 2000;

  logic clk1M = 1'b0;
  logic rst_n;
  logic host_low;
  wire  data_h;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk1M = ~clk1M;

  pullup (data_h);
  assign data_h = host_low ? 1'b0 : 1'bz;

  humidity_responder_if bus ();

  humidity_responder #(
    .T_START_MIN (T_START_MIN),
    .T_WAIT      (T_WAIT),
    .T_RESP      (T_RESP),
    .T_BIT_LOW   (T_BIT_LOW),
    .T_ZERO      (T_ZERO),
    .T_ONE       (T_ONE)
  ) dut (
    .clk1M  (clk1M),
    .rst_n  (rst_n),
    .Data_H (data_h),
    .bus    (bus)
  );

  initial begin
    #950000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1M);
    #1;
  endtask

  // Number of consecutive samples at level lvl, starting at the current sample.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (data_h === lvl && n < RUN_MAX) begin
      n++;
      tick();
    end
  endtask

  // Line is sampled low on exactly low_cycles rising edges.
  task automatic host_start(input int low_cycles);
    host_low = 1'b1;
    repeat (low_cycles) @(posedge clk1M);
    #1 host_low = 1'b0;
  endtask

  // Reference frame: {hum, temp, byte-sum mod 256}.
  function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t);
    int s;
    s = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
    return {h, t, 8'(s % 256)};
  endfunction

  task automatic receive_frame(input logic [39:0] exp, input bit chg, input logic [15:0] new_h);
    int          n;
    int          want;
    logic [39:0] rx;
    rx = '0;
    n  = 0;
    while (bus.mstate !== 3'd2 && n < 64) begin
      tick();
      n++;
    end
    check("wait_reached", 64'(bus.mstate), 64'd2);
    if (bus.mstate !== 3'd2) return;
    check("busy_set", 64'(bus.busy), 64'd1);
    n = 0;
    while (bus.mstate === 3'd2 && n < RUN_MAX) begin
      n++;
      tick();
    end
    check("wait_len", 64'(n), 64'(T_WAIT));
    run_len(1'b0, n);
    check("resp_low_len", 64'(n), 64'(T_RESP));
    run_len(1'b1, n);
    check("resp_high_len", 64'(n), 64'(T_RESP));
    for (int i = 0; i < 40; i++) begin
      run_len(1'b0, n);
      check($sformatf("bit%0d_low_len", i), 64'(n), 64'(T_BIT_LOW));
      if (n >= RUN_MAX || n == 0) return;
      if (chg && i == 10) bus.hum_in = new_h;
      run_len(1'b1, n);
      want = exp[39-i] ? T_ONE : T_ZERO;
      check($sformatf("bit%0d_high_len", i), 64'(n), 64'(want));
      if (n >= RUN_MAX) return;
      rx = {rx[38:0], (n == T_ONE)};
    end
    run_len(1'b0, n);
    check("end_low_len", 64'(n), 64'(T_BIT_LOW));
    check("frame_data", 64'(rx), 64'(exp));
    check("frame_done_pulse", 64'(bus.frame_done), 64'd1);
    check("busy_clear", 64'(bus.busy), 64'd0);
    check("idle_after_frame", 64'(bus.mstate), 64'd0);
    tick();
    check("frame_done_single", 64'(bus.frame_done), 64'd0);
  endtask

  // Short host pulse: expect a short_start pulse and no response at all.
  task automatic short_case(input int low_cycles);
    int n;
    bit seen;
    bit bad;
    host_start(low_cycles);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 10) begin
      if (bus.short_start === 1'b1) seen = 1'b1;
      else tick();
      n++;
    end
    check("short_start_pulse", 64'(seen), 64'd1);
    tick();
    check("short_start_single", 64'(bus.short_start), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (data_h !== 1'b1 || bus.busy !== 1'b0 || bus.mstate !== 3'd0) bad = 1'b1;
      tick();
    end
    check("short_no_response", 64'(bad), 64'd0);
  endtask

  task automatic reset_pulse_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_line_released"}, 64'(data_h), 64'd1);
    check({tag, "_mstate"}, 64'(bus.mstate), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    begin
      bit bad;
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (bus.frame_done !== 1'b0 || data_h !== 1'b1 || bus.mstate !== 3'd0) bad = 1'b1;
      end
      check({tag, "_quiet_after"}, 64'(bad), 64'd0);
    end
  endtask

  initial begin
    logic [15:0] h, t, h2;
    int          n, k;
    logic [2:0]  prev_st;

    rst_n       = 1'b0;
    host_low    = 1'b0;
    bus.hum_in  = '0;
    bus.temp_in = '0;
    repeat (3) tick();
    check("rst_mstate", 64'(bus.mstate), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_short_start", 64'(bus.short_start), 64'd0);
    check("rst_line", 64'(data_h), 64'd1);
    rst_n = 1'b1;
    repeat (3) tick();

    // Reference frame with the minimum valid host pulse.
    bus.hum_in  = 16'h0190;
    bus.temp_in = 16'h00F5;
    host_start(T_START_MIN);
    receive_frame(40'h0190_00F5_86, 1'b0, 16'h0);
    repeat (5) tick();

    // One cycle too short, then a random short pulse.
    short_case(T_START_MIN - 1);
    short_case(int'($urandom_range(100, T_START_MIN - 2)));

    // Extreme payloads.
    bus.hum_in  = 16'hFFFF;
    bus.temp_in = 16'hFFFF;
    host_start(T_START_MIN);
    receive_frame(40'hFFFF_FFFF_FC, 1'b0, 16'h0);
    repeat (5) tick();
    bus.hum_in  = 16'h0000;
    bus.temp_in = 16'h0000;
    host_start(T_START_MIN);
    receive_frame(40'h0, 1'b0, 16'h0);
    repeat (5) tick();

    // Payload change mid-frame only reaches the following frame.
    h  = 16'($urandom);
    t  = 16'($urandom);
    h2 = ~h;
    bus.hum_in  = h;
    bus.temp_in = t;
    host_start(T_START_MIN + 5);
    receive_frame(model_frame(h, t), 1'b1, h2);
    repeat (5) tick();
    host_start(T_START_MIN);
    receive_frame(model_frame(h2, t), 1'b0, 16'h0);
    repeat (5) tick();

    // Reset during RESP_HIGH.
    host_start(T_START_MIN);
    n = 0;
    while (bus.mstate !== 3'd4 && n < RUN_MAX) begin
      tick();
      n++;
    end
    check("reach_resp_high", 64'(bus.mstate), 64'd4);
    repeat (10) tick();
    reset_pulse_check("rst_resp_high");

    // Reset during bit 20's low slot, while the responder holds the line low.
    host_start(T_START_MIN);
    k       = 0;
    n       = 0;
    prev_st = bus.mstate;
    while (k < 21 && n < 20000) begin
      tick();
      n++;
      if (bus.mstate === 3'd5 && prev_st !== 3'd5) k++;
      prev_st = bus.mstate;
    end
    check("reach_bit20", 64'(k), 64'd21);
    check("bit20_line_low", 64'(data_h), 64'd0);
    reset_pulse_check("rst_bit20");

    // Recovery after reset.
    h = 16'($urandom);
    t = 16'($urandom);
    bus.hum_in  = h;
    bus.temp_in = t;
    host_start(T_START_MIN);
    receive_frame(model_frame(h, t), 1'b0, 16'h0);

    // Back-to-back: next start one cycle after frame_done.
    host_start(T_START_MIN);
    receive_frame(model_frame(h, t), 1'b0, 16'h0);
    repeat (5) tick();

    // Random payloads and host pulse lengths.
    for (int r = 0; r < 2; r++) begin
      h = 16'($urandom);
      t = 16'($urandom);
      bus.hum_in  = h;
      bus.temp_in = t;
      host_start(int'($urandom_range(T_START_MIN, T_START_MIN + 200)));
      receive_frame(model_frame(h, t), 1'b0, 16'h0);
      repeat (5) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
